// File: rtl/elevator_scan_controller.sv
// SCAN elevator controller: car/hall-up/hall-down request registers, timed travel and door dwell.
// Define ESTOP_EN to add the estop input and the HALT state.
module elevator_scan_controller #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic               clk,
    input  logic               reset_n,
`ifdef ESTOP_EN
    input  logic               estop,
`endif
    input  logic [FLOORS-1:0]  inside_request,
    input  logic [FLOORS-1:0]  call_up,
    input  logic [FLOORS-1:0]  call_down,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               moving_up,
    output logic               moving_down,
    output logic               door_open,
    output logic               dir_up,
    output logic [FLOORS-1:0]  pending
);
    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]      TRAVEL_LD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]      DOOR_LD   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0]  UP_OK     = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0]  DN_OK     = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FLOOR_W-1:0] TOP       = FLOOR_W'(FLOORS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
`ifdef ESTOP_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q, dir_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [FLOORS-1:0]  car_q, car_d, up_q, up_d, dn_q, dn_d;
`ifdef ESTOP_EN
    state_t             ret_q, ret_d;
`endif

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_i = rst_sync_q[1];

    function automatic logic beyond(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f,
                                    input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (up ? (i > int'(f)) : (i < int'(f))) r = r | p[i];
        end
        return r;
    endfunction

    logic [FLOOR_W-1:0] eval_f;
    logic [FLOORS-1:0]  here_oh, req_all;
    logic [FLOORS-1:0]  car_clr, up_clr, dn_clr, car_abs, up_abs, dn_abs;
    logic               decide, ahead, h_same, h_opp, stop, freeze;

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        eval_f  = floor_q;
        decide  = 1'b0;
        car_clr = '0;
        up_clr  = '0;
        dn_clr  = '0;
        car_abs = '0;
        up_abs  = '0;
        dn_abs  = '0;
        freeze  = 1'b0;
`ifdef ESTOP_EN
        ret_d   = ret_q;
        freeze  = estop;
`endif
        req_all = car_q | up_q | dn_q;

        case (state_q)
            S_IDLE: decide = !freeze;
            S_MOVE: begin
                if (!freeze) begin
                    if (timer_q == '0) begin
                        if (dir_q && floor_q != TOP)        eval_f = floor_q + FLOOR_W'(1);
                        else if (!dir_q && floor_q != '0)   eval_f = floor_q - FLOOR_W'(1);
                        floor_d = eval_f;
                        decide  = 1'b1;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            S_DOOR: begin
                if (!freeze) begin
                    if (timer_q == '0) state_d = S_IDLE;
                    else               timer_d = timer_q - TW'(1);
                end
            end
`ifdef ESTOP_EN
            S_HALT: if (!estop) state_d = ret_q;
`endif
            default: state_d = S_IDLE;
        endcase

        here_oh         = '0;
        here_oh[eval_f] = 1'b1;
        ahead  = beyond(req_all, eval_f, dir_q);
        h_same = |(here_oh & (dir_q ? up_q : dn_q));
        h_opp  = |(here_oh & (dir_q ? dn_q : up_q));
        stop   = (|(here_oh & car_q)) | h_same | (h_opp & ~ahead);

        // While the door is open, presses for the bits just served are swallowed.
        if (state_q == S_DOOR) begin
            car_abs = here_oh;
            if (dir_q) up_abs = here_oh;
            else       dn_abs = here_oh;
        end

        if (decide) begin
            if (stop) begin
                state_d = S_DOOR;
                timer_d = DOOR_LD;
                car_clr = here_oh;
                if (h_same) begin
                    if (dir_q) up_clr = here_oh;
                    else       dn_clr = here_oh;
                end else if (h_opp && !ahead) begin
                    if (dir_q) dn_clr = here_oh;
                    else       up_clr = here_oh;
                    dir_d = ~dir_q;
                end
            end else if (ahead) begin
                state_d = S_MOVE;
                timer_d = TRAVEL_LD;
            end else if (state_q == S_IDLE && |req_all) begin
                dir_d   = ~dir_q;
                state_d = S_MOVE;
                timer_d = TRAVEL_LD;
            end else begin
                state_d = S_IDLE;
            end
        end

`ifdef ESTOP_EN
        if (estop && (state_q == S_IDLE || state_q == S_MOVE)) begin
            state_d = S_HALT;
            ret_d   = state_q;
        end
`endif

        car_d = (car_q | (inside_request & ~car_abs)) & ~car_clr;
        up_d  = (up_q | (call_up & UP_OK & ~up_abs)) & ~up_clr;
        dn_d  = (dn_q | (call_down & DN_OK & ~dn_abs)) & ~dn_clr;
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            floor_q <= '0;
            dir_q   <= 1'b1;
            timer_q <= '0;
            car_q   <= '0;
            up_q    <= '0;
            dn_q    <= '0;
`ifdef ESTOP_EN
            ret_q   <= S_IDLE;
`endif
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            car_q   <= car_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
`ifdef ESTOP_EN
            ret_q   <= ret_d;
`endif
        end
    end

    assign current_floor = floor_q;
    assign moving_up     = (state_q == S_MOVE) && dir_q;
    assign moving_down   = (state_q == S_MOVE) && !dir_q;
    assign door_open     = (state_q == S_DOOR);
    assign dir_up        = dir_q;
    assign pending       = car_q | up_q | dn_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Randomized and directed bench for elevator_scan_controller against an in-bench SCAN model.
`timescale 1ns/1ps
module tb_elevator_scan_controller;
    localparam int FLOORS = 8;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 6;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] inside_request = 8'h00;
    logic [7:0] call_up = 8'h00;
    logic [7:0] call_down = 8'h00;
    logic [2:0] current_floor;
    logic       moving_up, moving_down, door_open, dir_up;
    logic [7:0] pending;
`ifdef ESTOP_EN
    logic       estop = 1'b0;
`endif

    elevator_scan_controller #(
        .FLOORS(FLOORS), .FLOOR_W(3), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef ESTOP_EN
        .estop(estop),
`endif
        .inside_request(inside_request),
        .call_up(call_up),
        .call_down(call_down),
        .current_floor(current_floor),
        .moving_up(moving_up),
        .moving_down(moving_down),
        .door_open(door_open),
        .dir_up(dir_up),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model: request sets, floor number, direction, activity and cycles left in it.
    bit [7:0] m_car = 8'h00, m_hu = 8'h00, m_hd = 8'h00;
    int       m_floor = 0;
    bit       m_up = 1'b1;
    int       m_mode = M_IDLE;
    int       m_left = 0;
    int       m_sync = 0;
    bit       prev_door = 1'b0;
    int       door_floors[$];

    function automatic bit any_beyond(bit [7:0] p, int f, bit up);
        for (int i = 0; i < FLOORS; i++) begin
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        bit [7:0] keep_car, keep_up, keep_dn, clr_car, clr_up, clr_dn, p;
        bit decide, ahead, h_same, h_opp;
        keep_car = 8'hFF; keep_up = 8'h7F; keep_dn = 8'hFE;
        clr_car = 8'h00;  clr_up = 8'h00;  clr_dn = 8'h00;
        decide = 1'b0;
        if (!reset_n) begin
            m_car = 0; m_hu = 0; m_hd = 0; m_floor = 0; m_up = 1'b1;
            m_mode = M_IDLE; m_left = 0; m_sync = 0;
            return;
        end
        if (m_sync < 2) begin
            m_sync++;
            return;
        end
        p = m_car | m_hu | m_hd;
        if (m_mode == M_IDLE) begin
            decide = 1'b1;
        end else if (m_mode == M_MOVE) begin
            m_left--;
            if (m_left == 0) begin
                m_floor = m_floor + (m_up ? 1 : -1);
                decide = 1'b1;
            end
        end else begin
            keep_car[m_floor] = 1'b0;
            if (m_up) keep_up[m_floor] = 1'b0;
            else      keep_dn[m_floor] = 1'b0;
            m_left--;
            if (m_left == 0) m_mode = M_IDLE;
        end
        if (decide) begin
            ahead  = any_beyond(p, m_floor, m_up);
            h_same = m_up ? m_hu[m_floor] : m_hd[m_floor];
            h_opp  = m_up ? m_hd[m_floor] : m_hu[m_floor];
            if (m_car[m_floor] || h_same || (h_opp && !ahead)) begin
                m_mode = M_DOOR; m_left = DOOR;
                clr_car[m_floor] = 1'b1;
                if (h_same) begin
                    if (m_up) clr_up[m_floor] = 1'b1;
                    else      clr_dn[m_floor] = 1'b1;
                end else if (h_opp && !ahead) begin
                    if (m_up) clr_dn[m_floor] = 1'b1;
                    else      clr_up[m_floor] = 1'b1;
                    m_up = !m_up;
                end
            end else if (ahead) begin
                m_mode = M_MOVE; m_left = TRAVEL;
            end else if (m_mode == M_IDLE && p != 0) begin
                m_up = !m_up; m_mode = M_MOVE; m_left = TRAVEL;
            end else begin
                m_mode = M_IDLE;
            end
        end
        m_car = (m_car | (inside_request & keep_car)) & ~clr_car;
        m_hu  = (m_hu | (call_up & keep_up)) & ~clr_up;
        m_hd  = (m_hd | (call_down & keep_dn)) & ~clr_dn;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle_outputs",
              32'({current_floor, moving_up, moving_down, door_open, dir_up, pending}),
              32'({3'(m_floor), (m_mode == M_MOVE) && m_up, (m_mode == M_MOVE) && !m_up,
                   m_mode == M_DOOR, m_up, m_car | m_hu | m_hd}));
        if (door_open && !prev_door) door_floors.push_back(int'(current_floor));
        prev_door = door_open;
    endtask

    task automatic pulse(input logic [7:0] ir, input logic [7:0] cu, input logic [7:0] cd);
        inside_request = ir; call_up = cu; call_down = cd;
        tick();
        inside_request = 8'h00; call_up = 8'h00; call_down = 8'h00;
    endtask

    task automatic run_until_idle(input int limit, input string name);
        int k;
        k = 0;
        while (k < limit && (moving_up || moving_down || door_open || pending != 8'h00)) begin
            tick();
            k++;
        end
        check(name, 32'(k < limit), 32'd1);
    endtask

    initial begin
        int mv, dl, k;
        int exp_stops[3];
        exp_stops[0] = 4; exp_stops[1] = 6; exp_stops[2] = 3;

        // Reset held with a car request present
        inside_request = 8'h10;
        for (int i = 0; i < 3; i++) tick();
        check("rst_motion_door", 32'({current_floor, moving_up, moving_down, door_open}), 32'd0);
        check("rst_dir_up", 32'(dir_up), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        reset_n = 1'b1;
        inside_request = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_pending", 32'(pending), 32'd0);

        // Car request to floor 5 from floor 0
        pulse(8'h20, 8'h00, 8'h00);
        check("t2_latched", 32'(pending), 32'h20);
        mv = 0;
        for (k = 0; k < 100; k++) begin
            tick();
            if (door_open) break;
            if (moving_up) mv++;
        end
        check("t2_move_cycles", 32'(mv), 32'd20);
        check("t2_floor", 32'(current_floor), 32'd5);
        dl = 1;
        for (k = 0; k < 50; k++) begin
            tick();
            if (!door_open) break;
            dl++;
        end
        check("t2_door_cycles", 32'(dl), 32'd6);
        check("t2_pending", 32'(pending), 32'd0);

        // Go to floor 1, then up to 6 with hall calls latched while passing floor 2
        pulse(8'h02, 8'h00, 8'h00);
        run_until_idle(100, "t3_reach1");
        check("t3_floor1", 32'(current_floor), 32'd1);
        door_floors.delete();
        pulse(8'h40, 8'h00, 8'h00);
        for (k = 0; k < 60; k++) begin
            if (current_floor == 3'd2 && moving_up) break;
            tick();
        end
        check("t3_at2", 32'(k < 60), 32'd1);
        pulse(8'h00, 8'h10, 8'h08);
        run_until_idle(200, "t3_done");
        check("t3_nstops", 32'(door_floors.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("t3_stop_floor", 32'((i < door_floors.size()) ? door_floors[i] : 99), 32'(exp_stops[i]));

        // Door at floor 2 with a repeat car press during the dwell
        pulse(8'h04, 8'h00, 8'h00);
        for (k = 0; k < 60; k++) begin
            tick();
            if (door_open) break;
        end
        check("t4_floor", 32'(current_floor), 32'd2);
        dl = 1;
        for (int j = 0; j < 20; j++) begin
            inside_request = (j == 2) ? 8'h04 : 8'h00;
            tick();
            if (door_open) dl++;
        end
        inside_request = 8'h00;
        check("t4_door_cycles", 32'(dl), 32'd6);
        check("t4_pending", 32'(pending), 32'd0);

        // Invalid hall bits
        pulse(8'h00, 8'h80, 8'h01);
        for (int i = 0; i < 3; i++) tick();
        check("t5_pending", 32'(pending), 32'd0);
        check("t5_idle", 32'({moving_up, moving_down, door_open}), 32'd0);

        // Random traffic with a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            inside_request = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            call_up        = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            call_down      = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            if (c == 1500) reset_n = 1'b0;
            if (c == 1503) reset_n = 1'b1;
            tick();
        end
        inside_request = 8'h00; call_up = 8'h00; call_down = 8'h00;
        run_until_idle(800, "drain_idle");
        check("drain_pending", 32'(pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
